// File: rtl/memory_access_if.sv
// Data-memory bus between the LEGv8 memory-access stage (master) and a
// variable-latency data memory (slave), using a req/ack handshake.
interface memory_access_if #(
    parameter int N = 64
);
    logic         dm_req;
    logic         dm_we;
    logic [N-1:0] dm_addr;
    logic [N-1:0] dm_wdata;
    logic         dm_ack;
    logic [N-1:0] dm_rdata;

    modport master (
        output dm_req,
        output dm_we,
        output dm_addr,
        output dm_wdata,
        input  dm_ack,
        input  dm_rdata
    );

    modport slave (
        input  dm_req,
        input  dm_we,
        input  dm_addr,
        input  dm_wdata,
        output dm_ack,
        output dm_rdata
    );
endinterface

// File: rtl/memory_access.sv
// LEGv8 memory-access stage: runs loads/stores over a req/ack bus, stalls
// upstream while an access is outstanding, and resolves the branch select.
module memory_access #(
    parameter int N       = 64,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 memRead_M,
    input  logic                 memWrite_M,
    input  logic                 branch_M,
    input  logic                 zero_M,
    input  logic [N-1:0]         aluResult_M,
    input  logic [N-1:0]         writeData_M,
    memory_access_if.master      dm,
    output logic [N-1:0]         readData_M,
    output logic                 PCSrc_M,
    output logic                 stall_M,
    output logic                 misaligned_M,
    output logic                 memError_M
);
    localparam int              CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_r;
    logic           req_r;
    logic           we_r;
    logic [N-1:0]   addr_r;
    logic [N-1:0]   wdata_r;
    logic [N-1:0]   rdata_r;
    logic           err_r;
    logic [CW-1:0]  cnt_r;

    logic           op_s;
    logic           issue_s;
    logic           stall_s;
    logic           mis_s;

    // Doublewords must sit on an 8-byte boundary.
    function automatic logic is_misaligned(input logic [N-1:0] addr);
        return (addr[2:0] != 3'b000);
    endfunction

    assign op_s    = memRead_M | memWrite_M;
    assign issue_s = op_s & ~is_misaligned(aluResult_M);

    // Stall and misalignment flags decoded from state and the incoming op.
    always_comb begin
        stall_s = 1'b0;
        mis_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (op_s) begin
                    mis_s   = is_misaligned(aluResult_M);
                    stall_s = ~is_misaligned(aluResult_M);
                end else begin
                    mis_s   = 1'b0;
                    stall_s = 1'b0;
                end
            end
            ST_WAIT: stall_s = 1'b1;
            ST_DONE: stall_s = 1'b0;
            default: stall_s = 1'b0;
        endcase
    end

    // Access FSM: latch the op in IDLE, wait for ack or timeout, settle in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            rdata_r <= '0;
            err_r   <= 1'b0;
            cnt_r   <= '0;
        end else begin
            err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (issue_s) begin
                        addr_r  <= aluResult_M;
                        wdata_r <= writeData_M;
                        we_r    <= memWrite_M;
                        cnt_r   <= '0;
                        req_r   <= 1'b1;
                        state_r <= ST_WAIT;
                    end else begin
                        req_r   <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    // An ack in the last allowed cycle wins over the timeout.
                    if (dm.dm_ack) begin
                        if (!we_r) begin
                            rdata_r <= dm.dm_rdata;
                        end else begin
                            rdata_r <= rdata_r;
                        end
                        req_r   <= 1'b0;
                        state_r <= ST_DONE;
                    end else if (cnt_r == CNT_LAST) begin
                        if (!we_r) begin
                            rdata_r <= '0;
                        end else begin
                            rdata_r <= rdata_r;
                        end
                        err_r   <= 1'b1;
                        req_r   <= 1'b0;
                        state_r <= ST_DONE;
                    end else begin
                        if (cnt_r != CNT_MAX) begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end else begin
                            cnt_r <= cnt_r;
                        end
                        state_r <= ST_WAIT;
                    end
                end
                // The completing instruction is still on the inputs here; never re-issue it.
                ST_DONE: begin
                    req_r   <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    req_r   <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign dm.dm_req    = req_r;
    assign dm.dm_we     = we_r;
    assign dm.dm_addr   = addr_r;
    assign dm.dm_wdata  = wdata_r;

    assign readData_M   = rdata_r;
    assign memError_M   = err_r;
    assign stall_M      = stall_s;
    assign misaligned_M = mis_s;
    assign PCSrc_M      = branch_M & zero_M;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access (TIMEOUT = 4): per-cycle vector tables
// plus a hand-written asynchronous reset sequence taken in the middle of WAIT.
module tb_memory_access;
    logic        clk;
    logic        reset;
    logic        memRead_M;
    logic        memWrite_M;
    logic        branch_M;
    logic        zero_M;
    logic [63:0] aluResult_M;
    logic [63:0] writeData_M;
    logic [63:0] readData_M;
    logic        PCSrc_M;
    logic        stall_M;
    logic        misaligned_M;
    logic        memError_M;

    int checks   = 0;
    int failures = 0;

    memory_access_if #(.N(64)) dmi ();

    memory_access #(.N(64), .TIMEOUT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .memRead_M    (memRead_M),
        .memWrite_M   (memWrite_M),
        .branch_M     (branch_M),
        .zero_M       (zero_M),
        .aluResult_M  (aluResult_M),
        .writeData_M  (writeData_M),
        .dm           (dmi.master),
        .readData_M   (readData_M),
        .PCSrc_M      (PCSrc_M),
        .stall_M      (stall_M),
        .misaligned_M (misaligned_M),
        .memError_M   (memError_M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr, br, zr;
        logic [63:0] addr, wdata;
        logic        ack;
        logic [63:0] rdata;
        logic        x_req, x_we, x_stall, x_mis, x_pc, x_err;
        logic [63:0] x_addr, x_wdata, x_rdata;
    } vec_t;

    localparam logic [63:0] DB = 64'h0000_0000_DEAD_BEEF;

    vec_t vec [17];
    vec_t tov [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        memRead_M   = v.rd;
        memWrite_M  = v.wr;
        branch_M    = v.br;
        zero_M      = v.zr;
        aluResult_M = v.addr;
        writeData_M = v.wdata;
        dmi.dm_ack  = v.ack;
        dmi.dm_rdata = v.rdata;
        @(negedge clk);
        chk({tag, " dm_req"},   64'(dmi.dm_req),   64'(v.x_req));
        chk({tag, " dm_we"},    64'(dmi.dm_we),    64'(v.x_we));
        chk({tag, " stall"},    64'(stall_M),      64'(v.x_stall));
        chk({tag, " misalign"}, 64'(misaligned_M), 64'(v.x_mis));
        chk({tag, " pcsrc"},    64'(PCSrc_M),      64'(v.x_pc));
        chk({tag, " memerr"},   64'(memError_M),   64'(v.x_err));
        chk({tag, " dm_addr"},  dmi.dm_addr,       v.x_addr);
        chk({tag, " dm_wdata"}, dmi.dm_wdata,      v.x_wdata);
        chk({tag, " readdata"}, readData_M,        v.x_rdata);
    endtask

    task automatic set_idle_inputs();
        memRead_M    = 1'b0;
        memWrite_M   = 1'b0;
        branch_M     = 1'b0;
        zero_M       = 1'b0;
        aluResult_M  = 64'h0;
        writeData_M  = 64'h0;
        dmi.dm_ack   = 1'b0;
        dmi.dm_rdata = 64'h0;
    endtask

    initial begin
        // rd wr br zr addr wdata ack rdata | req we stall mis pc err addr wdata rdata
        vec[0]  = '{1'b1,1'b0,1'b0,1'b0, 64'h40, 64'h0, 1'b0, 64'h0,    1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 64'h0,  64'h0,    64'h0};
        vec[1]  = '{1'b1,1'b0,1'b0,1'b0, 64'h40, 64'h0, 1'b1, DB,       1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 64'h40, 64'h0,    64'h0};
        vec[2]  = '{1'b1,1'b0,1'b0,1'b0, 64'h40, 64'h0, 1'b0, 64'h0,    1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 64'h40, 64'h0,    DB};
        vec[3]  = '{1'b0,1'b0,1'b0,1'b0, 64'h0,  64'h0, 1'b0, 64'h0,    1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 64'h40, 64'h0,    DB};
        vec[4]  = '{1'b0,1'b1,1'b0,1'b0, 64'h18, 64'h1234, 1'b0, 64'h0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 64'h40, 64'h0,    DB};
        vec[5]  = '{1'b0,1'b1,1'b0,1'b0, 64'h18, 64'h1234, 1'b0, 64'h0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 64'h18, 64'h1234, DB};
        vec[6]  = '{1'b0,1'b1,1'b0,1'b0, 64'h18, 64'h1234, 1'b0, 64'h0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 64'h18, 64'h1234, DB};
        vec[7]  = '{1'b0,1'b1,1'b0,1'b0, 64'h18, 64'h1234, 1'b1, 64'hAAAA, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 64'h18, 64'h1234, DB};
        vec[8]  = '{1'b0,1'b1,1'b0,1'b0, 64'h18, 64'h1234, 1'b0, 64'h0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 64'h18, 64'h1234, DB};
        vec[9]  = '{1'b1,1'b0,1'b0,1'b0, 64'h43, 64'h0, 1'b0, 64'h0,    1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 64'h18, 64'h1234, DB};
        vec[10] = '{1'b1,1'b0,1'b0,1'b0, 64'h43, 64'h0, 1'b0, 64'h0,    1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 64'h18, 64'h1234, DB};
        vec[11] = '{1'b0,1'b0,1'b1,1'b1, 64'h0,  64'h0, 1'b0, 64'h0,    1'b0,1'b1,1'b0,1'b0,1'b1,1'b0, 64'h18, 64'h1234, DB};
        vec[12] = '{1'b1,1'b0,1'b1,1'b1, 64'h08, 64'h0, 1'b0, 64'h0,    1'b0,1'b1,1'b1,1'b0,1'b1,1'b0, 64'h18, 64'h1234, DB};
        vec[13] = '{1'b1,1'b0,1'b1,1'b1, 64'h08, 64'h0, 1'b1, 64'h55,   1'b1,1'b0,1'b1,1'b0,1'b1,1'b0, 64'h08, 64'h0,    DB};
        vec[14] = '{1'b1,1'b0,1'b1,1'b0, 64'h08, 64'h0, 1'b0, 64'h0,    1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 64'h08, 64'h0,    64'h55};
        vec[15] = '{1'b0,1'b0,1'b1,1'b0, 64'h0,  64'h0, 1'b1, 64'hFF,   1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 64'h08, 64'h0,    64'h55};
        vec[16] = '{1'b0,1'b0,1'b0,1'b0, 64'h0,  64'h0, 1'b0, 64'h0,    1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 64'h08, 64'h0,    64'h55};

        // Timeout with no ack, then a back-to-back load acked in the last allowed cycle.
        tov[0]  = '{1'b1,1'b0,1'b0,1'b0, 64'h20, 64'h0, 1'b0, 64'h0,  1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 64'h08, 64'h0, 64'h55};
        tov[1]  = '{1'b1,1'b0,1'b0,1'b0, 64'h20, 64'h0, 1'b0, 64'h0,  1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 64'h20, 64'h0, 64'h55};
        tov[2]  = tov[1];
        tov[3]  = tov[1];
        tov[4]  = tov[1];
        tov[5]  = '{1'b1,1'b0,1'b0,1'b0, 64'h20, 64'h0, 1'b0, 64'h0,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 64'h20, 64'h0, 64'h0};
        tov[6]  = '{1'b1,1'b0,1'b0,1'b0, 64'h28, 64'h0, 1'b0, 64'h0,  1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 64'h20, 64'h0, 64'h0};
        tov[7]  = '{1'b1,1'b0,1'b0,1'b0, 64'h28, 64'h0, 1'b0, 64'h0,  1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 64'h28, 64'h0, 64'h0};
        tov[8]  = tov[7];
        tov[9]  = tov[7];
        tov[10] = '{1'b1,1'b0,1'b0,1'b0, 64'h28, 64'h0, 1'b1, 64'h77, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 64'h28, 64'h0, 64'h0};
        tov[11] = '{1'b1,1'b0,1'b0,1'b0, 64'h28, 64'h0, 1'b0, 64'h0,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 64'h28, 64'h0, 64'h77};
        tov[12] = '{1'b0,1'b0,1'b0,1'b0, 64'h0,  64'h0, 1'b0, 64'h0,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 64'h28, 64'h0, 64'h77};

        reset = 1'b0;
        set_idle_inputs();
        repeat (2) @(negedge clk);
        chk("rst dm_req",   64'(dmi.dm_req),   64'h0);
        chk("rst dm_we",    64'(dmi.dm_we),    64'h0);
        chk("rst dm_addr",  dmi.dm_addr,       64'h0);
        chk("rst dm_wdata", dmi.dm_wdata,      64'h0);
        chk("rst readdata", readData_M,        64'h0);
        chk("rst memerr",   64'(memError_M),   64'h0);
        chk("rst stall",    64'(stall_M),      64'h0);
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            run_vec(vec[i], $sformatf("v%0d", i));
        end
        for (int i = 0; i < 13; i++) begin
            run_vec(tov[i], $sformatf("t%0d", i));
        end

        // Reset asserted mid-WAIT, then a stray ack after release.
        @(posedge clk);
        #1;
        memRead_M   = 1'b1;
        aluResult_M = 64'h30;
        @(negedge clk);
        chk("rw c0 stall", 64'(stall_M), 64'h1);
        @(posedge clk);
        #1;
        chk("rw c1 dm_req", 64'(dmi.dm_req), 64'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("rw async dm_req",   64'(dmi.dm_req), 64'h0);
        chk("rw async readdata", readData_M,      64'h0);
        chk("rw async dm_addr",  dmi.dm_addr,     64'h0);
        set_idle_inputs();
        @(posedge clk);
        #1;
        reset        = 1'b1;
        dmi.dm_ack   = 1'b1;
        dmi.dm_rdata = 64'h99;
        @(negedge clk);
        chk("rw stray dm_req",   64'(dmi.dm_req), 64'h0);
        chk("rw stray stall",    64'(stall_M),    64'h0);
        @(posedge clk);
        #1;
        dmi.dm_ack   = 1'b0;
        dmi.dm_rdata = 64'h0;
        @(negedge clk);
        chk("rw after readdata", readData_M,      64'h0);
        chk("rw after dm_req",   64'(dmi.dm_req), 64'h0);
        chk("rw after memerr",   64'(memError_M), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
